// File: rtl/lab1_pkg.sv
// Shared widths, fixed-point formats and Taylor coefficients for the e^x evaluator.
package lab1_pkg;

  localparam int WIDTHIN  = 16;
  localparam int WIDTHOUT = 32;
  localparam int FRAC_IN  = 14;
  localparam int FRAC_OUT = 25;
  localparam int STAGES   = 5;

  localparam logic [WIDTHOUT-1:0] A0 = 32'd33554432;
  localparam logic [WIDTHOUT-1:0] A1 = 32'd33554432;
  localparam logic [WIDTHOUT-1:0] A2 = 32'd16777216;
  localparam logic [WIDTHOUT-1:0] A3 = 32'd5592517;
  localparam logic [WIDTHOUT-1:0] A4 = 32'd1398213;
  localparam logic [WIDTHOUT-1:0] A5 = 32'd279508;

  // Addend for Horner stage k lives at index k-1: stage 1 adds A4, stage 5 adds A0.
  localparam logic [STAGES-1:0][WIDTHOUT-1:0] HORNER_C = {A0, A1, A2, A3, A4};

endpackage

// File: rtl/lab1_horner_stage.sv
// One registered Horner step: acc_out = trunc(acc_in * x_in) + C, with x and valid carried along.
module horner_stage
  import lab1_pkg::*;
#(
  parameter logic [WIDTHOUT-1:0] C = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTHOUT-1:0] acc_in,
  input  logic [WIDTHIN-1:0]  x_in,
  input  logic                v_in,
  output logic [WIDTHOUT-1:0] acc_out,
  output logic [WIDTHIN-1:0]  x_out,
  output logic                v_out
);

  logic [WIDTHOUT+WIDTHIN-1:0] prod;
  logic [WIDTHOUT-1:0]         acc_d, acc_q;
  logic [WIDTHIN-1:0]          x_d, x_q;
  logic                        v_d, v_q;

  always_comb begin
    prod  = {{WIDTHIN{1'b0}}, acc_in} * {{WIDTHOUT{1'b0}}, x_in};
    acc_d = acc_q;
    x_d   = x_q;
    v_d   = v_q;
    if (enable) begin
      // Q9.39 product back to Q7.25 by truncation; the top two bits are always zero for x < 4.
      acc_d = WIDTHOUT'(prod >> FRAC_IN) + C;
      x_d   = x_in;
      v_d   = v_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      x_q   <= '0;
      v_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      v_q   <= v_d;
    end
  end

  assign acc_out = acc_q;
  assign x_out   = x_q;
  assign v_out   = v_q;

endmodule

// File: rtl/lab1.sv
// Six-register pipelined Taylor evaluator of e^x (Q2.14 in, Q7.25 out), stalled as a whole by i_ready.
module lab1
  import lab1_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic                i_ready,
  output logic                o_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_x,
  output logic [WIDTHOUT-1:0] o_y
);

  logic                              enable;
  logic [WIDTHIN-1:0]                x0_d, x0_q;
  logic                              v0_d, v0_q;
  logic [STAGES:0][WIDTHOUT-1:0]     acc;
  logic [STAGES:0][WIDTHIN-1:0]      xs;
  logic [STAGES:0]                   vs;
  logic                              x_last_unused;

  assign enable  = i_ready;
  assign o_ready = i_ready;

  always_comb begin
    x0_d = x0_q;
    v0_d = v0_q;
    if (enable) begin
      x0_d = i_x;
      v0_d = i_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q <= '0;
      v0_q <= 1'b0;
    end else begin
      x0_q <= x0_d;
      v0_q <= v0_d;
    end
  end

  // Horner seed is the highest-order coefficient; it never changes.
  assign acc[0] = A5;
  assign xs[0]  = x0_q;
  assign vs[0]  = v0_q;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    horner_stage #(.C(HORNER_C[k-1])) u_stage (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .acc_in  (acc[k-1]),
      .x_in    (xs[k-1]),
      .v_in    (vs[k-1]),
      .acc_out (acc[k]),
      .x_out   (xs[k]),
      .v_out   (vs[k])
    );
  end

  assign x_last_unused = ^xs[STAGES];

  assign o_y     = acc[STAGES];
  assign o_valid = vs[STAGES];

endmodule

// File: tb/tb_lab1.sv
// Directed and scoreboarded checks of the lab1 e^x pipeline: latency, exact vectors, stalls, bubbles, reset.
module tb_lab1;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready;
  logic        o_valid, o_ready;
  logic [15:0] i_x;
  logic [31:0] o_y;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  lab1 dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .o_y     (o_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-accurate Horner evaluation: 48-bit product, keep [45:14], 32-bit add.
  function automatic logic [31:0] ref_y(input logic [15:0] x);
    logic [31:0] c [5];
    logic [31:0] acc;
    logic [47:0] p;
    c = '{32'd1398213, 32'd5592517, 32'd16777216, 32'd33554432, 32'd33554432};
    acc = 32'd279508;
    for (int k = 0; k < 5; k++) begin
      p   = {16'b0, acc} * {32'b0, x};
      acc = p[45:14] + c[k];
    end
    return acc;
  endfunction

  function automatic logic within_tol(input logic [15:0] x, input logic [31:0] y);
    real xr, yr, ye, d;
    xr = real'(x) / 16384.0;
    yr = real'(y) / 33554432.0;
    ye = 1.0 + xr + 0.5*xr*xr + 0.16667*xr**3 + 0.04167*xr**4 + 0.00833*xr**5;
    d  = yr - ye;
    if (d < 0.0) d = -d;
    return d < 0.045;
  endfunction

  // Transfers are decided by signals that are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_valid && o_ready) exp_q.push_back(i_x);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          logic [15:0] xx;
          xx = exp_q.pop_front();
          check("stream_y", o_y, ref_y(xx));
          check("stream_tol", {31'b0, within_tol(xx, o_y)}, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single sample: check latency boundary and exact/hand-computed result.
  task automatic run_one(input string tag, input logic [15:0] x, input logic [31:0] exp);
    i_x = x; i_valid = 1'b1;
    tick();
    i_valid = 1'b0; i_x = 16'hBEEF;
    repeat (4) tick();
    check({tag, "_early_v"}, {31'b0, o_valid}, 32'd0);
    tick();
    check({tag, "_v"}, {31'b0, o_valid}, 32'd1);
    check({tag, "_y"}, o_y, exp);
    check({tag, "_tol"}, {31'b0, within_tol(x, o_y)}, 32'd1);
    tick();
  endtask

  logic [31:0] hold_y;
  logic        hold_v;

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_x = '0;
    #2;
    check("rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("rst_o_y", o_y, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    run_one("x0",    16'd0,     32'd33554432);
    run_one("x1",    16'd16384, 32'd91156318);
    run_one("x2",    16'd32768, 32'd243827960);
    run_one("xhalf", 16'd8192,  32'd55321139);
    run_one("xmax",  16'd65535, ref_y(16'd65535));
    check("xmax_no_ovf", {31'b0, (ref_y(16'd65535) > 32'd1426063360) && (ref_y(16'd65535) < 32'd1442840576)}, 32'd1);

    // Back-to-back random stream, checked by the scoreboard.
    for (int i = 0; i < 50; i++) begin
      i_x = 16'($urandom_range(0, 65535)); i_valid = 1'b1;
      tick();
    end

    // Mid-stream stall with valid data in flight.
    hold_y = o_y; hold_v = o_valid;
    i_ready = 1'b0;
    i_x = 16'd1234;
    #1;
    check("stall_o_ready", {31'b0, o_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_hold_y", o_y, hold_y);
      check("stall_hold_v", {31'b0, o_valid}, {31'b0, hold_v});
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_x = 16'($urandom_range(0, 65535)); i_valid = 1'b1;
      tick();
    end

    // Bubble with garbage operand.
    i_valid = 1'b0; i_x = 16'd23;
    repeat (3) tick();
    i_valid = 1'b1; i_x = 16'd16384;
    tick();
    i_x = 16'd40000;
    tick();
    i_valid = 1'b0;
    repeat (8) tick();
    check("drain_empty", exp_q.size(), 32'd0);

    // Reset with samples in flight.
    for (int i = 0; i < 7; i++) begin
      i_x = 16'($urandom_range(0, 65535)); i_valid = 1'b1;
      tick();
    end
    reset = 1'b1; i_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_o_valid", {31'b0, o_valid}, 32'd0);
    check("midrst_o_y", o_y, 32'd0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("post_rst_quiet", {31'b0, o_valid}, 32'd0);
    run_one("post_rst_x1", 16'd16384, 32'd91156318);
    check("final_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
